mu0_ctrl: RTL and testbench

- Fetch/execute control FSM for the MU0 datapath.
- Generates the enables for the 12-bit PC, the 16-bit IR and the 16-bit Acc register stages, plus the mux selects, ALU function and memory strobes.
- Sits directly upstream of the PC register: it drives the register's En and, through the ALU, its D.
- Adds a memory-ready handshake so slow memory can stall the core.

---
 rtl/mu0_ctrl.sv | 120 ++++++++++++
 tb/tb_mu0_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_ctrl.sv
// MU0 fetch/execute control FSM with memory-ready stall handshake.
// Optional retired-instruction counter enabled by MU0_CTRL_ICOUNT_EN.
module mu0_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       Z,
  input  logic       N,
  input  logic       Mem_rdy,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic [1:0] ALU_fs,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic       MEM_rd,
  output logic       MEM_wr,
  output logic       Halted
`ifdef MU0_CTRL_ICOUNT_EN
  ,
  output logic [15:0] Icount
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXEC    = 2'b01,
    HALT    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t state, nxt;

  always_ff @(posedge Clk) begin
    if (Reset) state <= FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    ALU_fs   = 2'b00;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    MEM_rd   = 1'b0;
    MEM_wr   = 1'b0;
    Halted   = 1'b0;
    case (state)
      FETCH: begin
        Addr_sel = 1'b0;
        MEM_rd   = 1'b1;
        X_sel    = 1'b1;
        ALU_fs   = 2'b10;
        IR_En    = Mem_rdy;
        PC_En    = Mem_rdy;
        if (Mem_rdy) nxt = EXEC;
      end
      EXEC: begin
        nxt = FETCH;
        case (F)
          4'h0: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            ALU_fs   = 2'b00;
            Acc_En   = Mem_rdy;
          end
          4'h1: begin
            Addr_sel = 1'b1;
            MEM_wr   = 1'b1;
          end
          4'h2, 4'h3: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            ALU_fs   = (F == 4'h2) ? 2'b01 : 2'b11;
            Acc_En   = Mem_rdy;
          end
          4'h4, 4'h5, 4'h6: begin
            Y_sel  = 1'b1;
            ALU_fs = 2'b00;
            PC_En  = (F == 4'h4) ? 1'b1 :
                     (F == 4'h5) ? ~N : ~Z;
          end
          4'h7: nxt = HALT;
          default: ;
        endcase
        // memory ops hold the access until memory answers
        if (F < 4'h4 && !Mem_rdy) nxt = EXEC;
      end
      HALT: Halted = 1'b1;
      default: nxt = FETCH;
    endcase
    if (Reset) begin
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      Addr_sel = 1'b0;
      ALU_fs   = 2'b00;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      Acc_En   = 1'b0;
      MEM_rd   = 1'b0;
      MEM_wr   = 1'b0;
      Halted   = 1'b0;
    end
  end

`ifdef MU0_CTRL_ICOUNT_EN
  logic retire;
  assign retire = (state == EXEC) && (nxt != EXEC);

  always_ff @(posedge Clk) begin
    if (Reset)       Icount <= 16'h0000;
    else if (retire) Icount <= Icount + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_mu0_ctrl.sv
// Self-checking bench for mu0_ctrl: vector table, corner sequences,
// and random stimulus against an instruction-level reference model.
module tb_mu0_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] F;
  logic       Z, N, Mem_rdy;
  logic       X_sel, Y_sel, Addr_sel;
  logic [1:0] ALU_fs;
  logic       PC_En, IR_En, Acc_En;
  logic       MEM_rd, MEM_wr, Halted;
`ifdef MU0_CTRL_ICOUNT_EN
  logic [15:0] Icount;
`endif

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mu0_ctrl dut (
    .Clk(Clk), .Reset(Reset), .F(F), .Z(Z), .N(N),
    .Mem_rdy(Mem_rdy), .X_sel(X_sel), .Y_sel(Y_sel),
    .Addr_sel(Addr_sel), .ALU_fs(ALU_fs), .PC_En(PC_En),
    .IR_En(IR_En), .Acc_En(Acc_En), .MEM_rd(MEM_rd),
    .MEM_wr(MEM_wr), .Halted(Halted)
`ifdef MU0_CTRL_ICOUNT_EN
    , .Icount(Icount)
`endif
  );

  // {X,Y,Addr,fs[1:0],PC,IR,Acc,rd,wr,Halted}
  localparam logic [10:0] O_ZERO = 11'b000_00_000_000;
  localparam logic [10:0] O_FET  = 11'b100_10_110_100;
  localparam logic [10:0] O_FSTL = 11'b100_10_000_100;
  localparam logic [10:0] O_LDA  = 11'b001_00_001_100;
  localparam logic [10:0] O_ADD  = 11'b001_01_001_100;
  localparam logic [10:0] O_SUB  = 11'b001_11_001_100;
  localparam logic [10:0] O_STA  = 11'b001_00_000_010;
  localparam logic [10:0] O_JT   = 11'b010_00_100_000;
  localparam logic [10:0] O_JN   = 11'b010_00_000_000;
  localparam logic [10:0] O_HALT = 11'b000_00_000_001;

  typedef struct {
    logic       rst;
    logic [3:0] f;
    logic       z;
    logic       n;
    logic       rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [10:0] outs();
    return {X_sel, Y_sel, Addr_sel, ALU_fs, PC_En,
            IR_En, Acc_En, MEM_rd, MEM_wr, Halted};
  endfunction

  task automatic check(input string nm,
                       input logic [10:0] exp);
    logic [10:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic check16(input string nm,
                         input logic [15:0] got,
                         input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // called at posedge+1; checks mid-cycle, returns at next posedge+1
  task automatic step(input logic rst, input logic [3:0] f,
                      input logic z, input logic n,
                      input logic rdy, input logic [10:0] exp,
                      input string nm);
    Reset = rst; F = f; Z = z; N = n; Mem_rdy = rdy;
    #4;
    check(nm, exp);
    @(posedge Clk); #1;
  endtask

  // instruction-level reference: halted, or waiting for fetch,
  // or holding a fetched opcode
  bit         m_halt;
  bit         m_have;
  logic [15:0] m_cnt;

  function automatic logic [10:0] model_out(
      bit rst, bit halt, bit have, logic [3:0] f,
      bit z, bit n, bit rdy);
    logic x, y, a, pc, ir, acc, rd, wr, h;
    logic [1:0] fs;
    {x, y, a, pc, ir, acc, rd, wr, h} = '0;
    fs = 2'b00;
    if (rst) return O_ZERO;
    if (halt) h = 1;
    else if (!have) begin
      x = 1; fs = 2'd2; rd = 1; pc = rdy; ir = rdy;
    end else if (f <= 3) begin
      a = 1;
      if (f == 1) wr = 1;
      else begin
        rd = 1;
        acc = rdy;
        fs = (f == 0) ? 2'd0 : (f == 2) ? 2'd1 : 2'd3;
      end
    end else if (f <= 6) begin
      y = 1;
      pc = (f == 4) ? 1'b1 : (f == 5) ? !n : !z;
    end
    return {x, y, a, fs, pc, ir, acc, rd, wr, h};
  endfunction

  task automatic model_step(bit rst, logic [3:0] f, bit rdy);
    if (rst) begin
      m_halt = 0; m_have = 0; m_cnt = 0;
    end else if (m_halt) begin
    end else if (!m_have) begin
      if (rdy) m_have = 1;
    end else if (f > 3 || rdy) begin
      m_have = 0;
      m_cnt++;
      if (f == 7) m_halt = 1;
    end
  endtask

  initial begin
    logic [3:0] rf;
    bit rr, rz, rn, ry;
    tbl = '{
      '{1, 4'h0, 0, 0, 1, O_ZERO},
      '{1, 4'h7, 1, 1, 1, O_ZERO},
      '{0, 4'h0, 0, 0, 1, O_FET},
      '{0, 4'h0, 0, 0, 1, O_LDA},
      '{0, 4'h5, 0, 1, 1, O_FET},
      '{0, 4'h5, 0, 1, 1, O_JN},
      '{0, 4'h5, 0, 0, 1, O_FET},
      '{0, 4'h5, 0, 0, 1, O_JT},
      '{0, 4'h2, 0, 0, 0, O_FSTL},
      '{0, 4'h2, 0, 0, 1, O_FET},
      '{0, 4'h2, 1, 0, 1, O_ADD},
      '{0, 4'h6, 1, 0, 1, O_FET},
      '{0, 4'h6, 1, 0, 1, O_JN},
      '{0, 4'h6, 0, 0, 1, O_FET},
      '{0, 4'h6, 0, 1, 0, O_JT},
      '{0, 4'h3, 0, 0, 1, O_FET},
      '{0, 4'h3, 0, 1, 1, O_SUB},
      '{0, 4'h9, 0, 0, 1, O_FET},
      '{0, 4'h9, 1, 1, 0, O_ZERO}
    };
    Reset = 1; F = 0; Z = 0; N = 0; Mem_rdy = 1;
    @(posedge Clk); #1;

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].f, tbl[i].z, tbl[i].n,
           tbl[i].rdy, tbl[i].exp, $sformatf("vec%0d", i));

    // STA held through a 3-cycle memory stall
    step(0, 4'h4, 0, 0, 1, O_FET, "sta_fetch0");
    step(0, 4'h4, 0, 0, 0, O_JT, "jmp_ignores_rdy");
    step(0, 4'h1, 0, 0, 1, O_FET, "sta_fetch");
`ifdef MU0_CTRL_ICOUNT_EN
    step(1, 4'h1, 0, 0, 1, O_ZERO, "sta_rst");
    step(0, 4'h1, 0, 0, 1, O_FET, "sta_fetch2");
`endif
    for (int i = 0; i < 3; i++) begin
      step(0, 4'h1, 0, 0, 0, O_STA, $sformatf("sta_stall%0d", i));
`ifdef MU0_CTRL_ICOUNT_EN
      check16("icount_stall", Icount, 16'd0);
`endif
    end
    step(0, 4'h1, 0, 0, 1, O_STA, "sta_done");
`ifdef MU0_CTRL_ICOUNT_EN
    check16("icount_after_sta", Icount, 16'd1);
`endif
    step(0, 4'h7, 0, 0, 1, O_FET, "sta_next_fetch");

    // three plain instructions then STP
    step(1, 4'h0, 0, 0, 1, O_ZERO, "pre_stp_rst");
    step(0, 4'h0, 0, 0, 1, O_FET, "i1_f");
    step(0, 4'h0, 0, 0, 1, O_LDA, "i1_e");
    step(0, 4'h4, 0, 0, 1, O_FET, "i2_f");
    step(0, 4'h4, 0, 0, 1, O_JT, "i2_e");
    step(0, 4'hB, 0, 0, 1, O_FET, "i3_f");
    step(0, 4'hB, 0, 0, 1, O_ZERO, "i3_e");
    step(0, 4'h7, 0, 0, 1, O_FET, "stp_f");
    step(0, 4'h7, 0, 0, 0, O_ZERO, "stp_e");
    for (int i = 0; i < 12; i++) begin
      step(0, 4'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), O_HALT, $sformatf("halt%0d", i));
`ifdef MU0_CTRL_ICOUNT_EN
      check16("icount_halt", Icount, 16'd4);
`endif
    end
    step(1, 4'h0, 0, 0, 1, O_ZERO, "halt_rst");
`ifdef MU0_CTRL_ICOUNT_EN
    check16("icount_rst", Icount, 16'd0);
`endif
    step(0, 4'h0, 0, 0, 1, O_FET, "after_halt");

    // reset in the middle of an LDA stall
    step(0, 4'h0, 0, 0, 0, 11'b001_00_000_100, "lda_stall");
    step(1, 4'h0, 0, 0, 0, O_ZERO, "stall_rst");
    step(0, 4'h0, 0, 0, 0, O_FSTL, "post_stall_rst");

    // random stimulus against the reference model
    Reset = 1; @(posedge Clk); #1;
    model_step(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rf = 4'($urandom);
      rz = 1'($urandom);
      rn = 1'($urandom);
      ry = ($urandom_range(3) != 0);
      rr = m_halt ? ($urandom_range(7) == 0)
                  : ($urandom_range(63) == 0);
      Reset = rr; F = rf; Z = rz; N = rn; Mem_rdy = ry;
      #4;
      check($sformatf("rand%0d", i),
            model_out(rr, m_halt, m_have, rf, rz, rn, ry));
      @(posedge Clk); #1;
      model_step(rr, rf, ry);
`ifdef MU0_CTRL_ICOUNT_EN
      check16($sformatf("rand_icount%0d", i), Icount, m_cnt);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
